branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Tracks in-flight predicted branches between fetch and execute and checks each
//  one against its resolved outcome. On a mispredict it issues a one-cycle PC
//  redirect and a timed squash sequence on flush[1:0], which clears the
//  direction predictor's two-stage history pipeline.
//  Sits downstream of the predictor: consumes its per-branch prediction and
//  drives its PCsel (actual taken) and flush inputs.
// PARAMETERS
//  XLEN          32  address width
//  DEPTH         4   in-flight entries; power of two, >=2
//  FLUSH_CYCLES  2   cycles flush[1:0] is held after a mispredict; 1..7
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous, active-high reset
//  pred_valid   in   1     fetch pushes one predicted branch this cycle
//  pred_taken   in   1     predicted direction (predictor 'prediction')
//  pred_pc      in   XLEN  PC of the branch
//  pred_target  in   XLEN  predicted target; meaningful only if pred_taken
//  res_valid    in   1     execute resolves the oldest in-flight branch
//  res_taken    in   1     actual direction
//  res_target   in   XLEN  actual computed target
//  full         out  1     DEPTH entries held
//  empty        out  1     no entries held
//  overflow     out  1     sticky: a push was dropped because the FIFO was full
//  pcsel        out  1     registered res_valid & res_taken; feeds predictor PCsel
//  redirect     out  1     one-cycle pulse: refetch from redirect_pc
//  redirect_pc  out  XLEN  correct next PC; valid while redirect=1
//  flush        out  2     predictor history squash; 2'b11 during FLUSH, else 2'b00
// BEHAVIOUR
//  - Reset (async): FIFO empty, pointers 0, state IDLE. full=0, empty=1,
//    overflow=0, pcsel=0, redirect=0, redirect_pc=0, flush=2'b00, counters 0.
//  - FIFO: circular buffer, log2(DEPTH)+1-bit count; pointers wrap at DEPTH.
//    Entry = {pc, taken, target}.
//  - Push: pred_valid & !full & state==IDLE. Push while full: dropped, overflow<=1.
//  - Pop: res_valid & !empty. res_valid while empty: ignored, no outputs change.
//  - Push and pop in the same cycle: both occur, count unchanged (legal when full).
//  - Mispredict (checked on pop): head.taken!=res_taken, or both taken and
//    head.target!=res_target.
//  - Correct redirect_pc: res_taken ? res_target : head.pc+4 (mod 2^XLEN).
//  - All outputs are registered; one cycle latency after the resolving edge.
//  - FSM:
//    - IDLE: on a mispredicting pop, at the next edge
//      - redirect<=1 and redirect_pc set
//      - FIFO cleared: all younger entries squashed, including a same-cycle push
//      - flush<=2'b11, cnt<=FLUSH_CYCLES-1, go to FLUSH
//    - FLUSH:
//      - redirect=0; flush=2'b11; pushes are ignored (no overflow set)
//      - res_valid is ignored (FIFO is empty)
//      - cnt decrements each cycle; at cnt==0 flush<=2'b00 and go to IDLE
//      - flush is therefore high for exactly FLUSH_CYCLES cycles
//  - pcsel updates on every valid pop, regardless of state or mispredict;
//    it is 0 in cycles with no pop.
//  - Reset asserted mid-FLUSH: immediate return to IDLE, all reset values.
// CONFIGURATION
//  BRU_STATS_EN defined:
//    - adds outputs br_count[15:0] (valid pops) and mp_count[15:0] (mispredicts)
//    - both saturate at 16'hFFFF and are cleared by rst
//  BRU_STATS_EN undefined: the ports and counters do not exist; the remaining
//    behaviour is identical.
// TESTING
//  1. Reset, push pc=0x100 taken=0; resolve res_taken=0
//     -> redirect=0, pcsel=0, flush=00, empty=1.
//  2. Push pc=0x200 taken=1 tgt=0x240; resolve taken=1 tgt=0x280
//     -> redirect=1 for 1 cycle, redirect_pc=0x280, flush=11 for 2 cycles.
//  3. Push 3 entries, oldest mispredicted not-taken (pc=0x300), resolve taken=0
//     -> redirect_pc=0x304, empty=1 next cycle, younger 2 squashed.
//  4. Fill DEPTH=4, push 5th -> overflow=1, full=1; push+pop same cycle -> count stays 4.
//  5. Mispredict, then assert rst during the second FLUSH cycle
//     -> flush=00, state IDLE, empty=1 immediately.
//  6. BRU_STATS_EN: 10 pops with 3 mispredicts -> br_count=10, mp_count=3;
//     res_valid on empty FIFO -> counts unchanged.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Tracks predicted branches from fetch to execute; redirects and squashes on mispredict.
// Optional BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pred_valid,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_pc,
   input  logic [XLEN-1:0] pred_target,
   input  logic            res_valid,
   input  logic            res_taken,
   input  logic [XLEN-1:0] res_target,
   output logic            full,
   output logic            empty,
   output logic            overflow,
   output logic            pcsel,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic [1:0]      flush
`ifdef BRU_STATS_EN
   ,
   output logic [15:0]     br_count,
   output logic [15:0]     mp_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t          state, state_nx;
   logic [2:0]      cnt, cnt_nx;
   logic [AW-1:0]   wr_ptr, wr_ptr_nx;
   logic [AW-1:0]   rd_ptr, rd_ptr_nx;
   logic [CW-1:0]   count, count_nx;
   logic            overflow_nx, pcsel_nx, redirect_nx;
   logic [XLEN-1:0] redirect_pc_nx;
   logic [1:0]      flush_nx;

   logic [XLEN-1:0] pc_mem  [DEPTH];
   logic [XLEN-1:0] tgt_mem [DEPTH];
   logic            tkn_mem [DEPTH];

   logic            pop, push_req, push, mispredict;
   logic [XLEN-1:0] head_pc, head_target;
   logic            head_taken;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   assign head_pc     = pc_mem[rd_ptr];
   assign head_target = tgt_mem[rd_ptr];
   assign head_taken  = tkn_mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a push while full still lands.
   assign pop        = res_valid & ~empty;
   assign push_req   = pred_valid & (state == S_IDLE);
   assign push       = push_req & (~full | pop);
   assign mispredict = pop & ((head_taken != res_taken) |
                       (head_taken & res_taken & (head_target != res_target)));

   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      wr_ptr_nx      = wr_ptr + AW'(push);
      rd_ptr_nx      = rd_ptr + AW'(pop);
      count_nx       = count + CW'(push) - CW'(pop);
      overflow_nx    = overflow | (push_req & full & ~pop);
      pcsel_nx       = pop & res_taken;
      redirect_nx    = 1'b0;
      redirect_pc_nx = redirect_pc;
      flush_nx       = flush;
      unique case (state)
         S_IDLE: begin
            if (mispredict) begin
               redirect_nx    = 1'b1;
               redirect_pc_nx = res_taken ? res_target : head_pc + XLEN'(4);
               wr_ptr_nx      = '0;
               rd_ptr_nx      = '0;
               count_nx       = '0;
               flush_nx       = 2'b11;
               cnt_nx         = 3'(FLUSH_CYCLES - 1);
               state_nx       = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (cnt == 3'd0) begin
               flush_nx = 2'b00;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt - 3'd1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow    <= 1'b0;
         pcsel       <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         flush       <= 2'b00;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         wr_ptr      <= wr_ptr_nx;
         rd_ptr      <= rd_ptr_nx;
         count       <= count_nx;
         overflow    <= overflow_nx;
         pcsel       <= pcsel_nx;
         redirect    <= redirect_nx;
         redirect_pc <= redirect_pc_nx;
         flush       <= flush_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]  <= '0;
            tgt_mem[i] <= '0;
            tkn_mem[i] <= 1'b0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]  <= pred_pc;
         tgt_mem[wr_ptr] <= pred_target;
         tkn_mem[wr_ptr] <= pred_taken;
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count <= '0;
         mp_count <= '0;
      end else begin
         if (pop && br_count != 16'hFFFF)
            br_count <= br_count + 16'd1;
         if (mispredict && mp_count != 16'hFFFF)
            mp_count <= mp_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: per-cycle vector table
// with a scoreboard queue, plus reset-during-flush and stats sequences.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_valid, pred_taken, res_valid, res_taken;
   logic [31:0] pred_pc, pred_target, res_target;
   logic        full, empty, overflow, pcsel, redirect;
   logic [31:0] redirect_pc;
   logic [1:0]  flush;
`ifdef BRU_STATS_EN
   logic [15:0] br_count, mp_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        pv, pt;
      logic [31:0] ppc, ptg;
      logic        rv, rt;
      logic [31:0] rtg;
      logic        fu, em, ov, ps, rd;
      logic [31:0] rpc;
      logic [1:0]  fl;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   branch_resolve_unit dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_pc(pred_pc), .pred_target(pred_target),
      .res_valid(res_valid), .res_taken(res_taken),
      .res_target(res_target),
      .full(full), .empty(empty), .overflow(overflow),
      .pcsel(pcsel), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush(flush)
`ifdef BRU_STATS_EN
      , .br_count(br_count), .mp_count(mp_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(
      input logic pv, pt, input logic [31:0] ppc, ptg,
      input logic rv, rt, input logic [31:0] rtg,
      input logic fu, em, ov, ps, rd,
      input logic [31:0] rpc, input logic [1:0] fl);
      vec_t v;
      v.pv = pv; v.pt = pt; v.ppc = ppc; v.ptg = ptg;
      v.rv = rv; v.rt = rt; v.rtg = rtg;
      v.fu = fu; v.em = em; v.ov = ov; v.ps = ps; v.rd = rd;
      v.rpc = rpc; v.fl = fl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Drive one cycle, queue its expectation, compare after the edge.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      pred_valid = v.pv; pred_taken = v.pt;
      pred_pc = v.ppc; pred_target = v.ptg;
      res_valid = v.rv; res_taken = v.rt; res_target = v.rtg;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".full"}, full, e.fu);
         chk({tag, ".empty"}, empty, e.em);
         chk({tag, ".overflow"}, overflow, e.ov);
         chk({tag, ".pcsel"}, pcsel, e.ps);
         chk({tag, ".redirect"}, redirect, e.rd);
         chk({tag, ".flush"}, flush, e.fl);
         if (e.rd)
            chk({tag, ".redirect_pc"}, redirect_pc, e.rpc);
      end
      pred_valid = 1'b0;
      res_valid  = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input logic fu, em, ov, input logic [1:0] fl, input string tag);
      apply(mk(0,0,0,0, 0,0,0, fu,em,ov,0,0, 0, fl), tag);
   endtask

   initial begin
      rst = 1'b1;
      pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0;

      //            pv pt ppc          ptg      rv rt rtg      fu em ov ps rd rpc        fl
      tbl.push_back(mk(1,0,32'h100,      0,       0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,0,0,       0,1,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,1,32'h200,      32'h240, 0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,1,32'h280, 0,1,0,1,1,32'h280,    2'b11));
      tbl.push_back(mk(1,0,32'h999,      0,       0,0,0,       0,1,0,0,0,0,          2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,1,32'h300,      32'h380, 0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h310,      0,       0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h320,      0,       0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,0,0,       0,1,0,0,1,32'h304,    2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,0,0,0,0,          2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,0,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,1,32'h55,  0,1,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h400,      0,       0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h410,      0,       0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h420,      0,       0,0,0,       0,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h430,      0,       0,0,0,       1,0,0,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h440,      0,       0,0,0,       1,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(1,1,32'h450,      32'h4a0, 1,0,0,       1,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,0,0,       0,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,0,0,       0,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,0,0,       0,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,1,32'h4a0, 0,1,1,1,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h500,      0,       0,0,0,       0,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,1,32'h600, 0,1,1,1,1,32'h600,    2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,1,0,0,0,          2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,1,0,0,0,          2'b00));
      tbl.push_back(mk(1,1,32'h700,      32'h780, 0,0,0,       0,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(1,0,32'h710,      0,       1,1,32'h790, 0,1,1,1,1,32'h790,    2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,1,0,0,0,          2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,1,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,0,0,       0,1,1,0,0,0,          2'b00));
      tbl.push_back(mk(1,1,32'hfffffffc, 32'h10,  0,0,0,       0,0,1,0,0,0,          2'b00));
      tbl.push_back(mk(0,0,0,            0,       1,0,0,       0,1,1,0,1,32'h0,      2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,1,0,0,0,          2'b11));
      tbl.push_back(mk(0,0,0,            0,       0,0,0,       0,1,1,0,0,0,          2'b00));

      #12;
      chk("reset.full", full, 0);
      chk("reset.empty", empty, 1);
      chk("reset.overflow", overflow, 0);
      chk("reset.pcsel", pcsel, 0);
      chk("reset.redirect", redirect, 0);
      chk("reset.redirect_pc", redirect_pc, 0);
      chk("reset.flush", flush, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("v%0d", i));

      // Reset asserted in the second flush cycle
      apply(mk(1,0,32'h800,0, 0,0,0, 0,0,1,0,0,0, 2'b00), "rf.push");
      apply(mk(0,0,0,0, 1,1,32'h900, 0,1,1,1,1,32'h900, 2'b11), "rf.mp");
      idle(0, 1, 1, 2'b11, "rf.flush2");
      rst = 1'b1;
      #1;
      chk("rf.rst.flush", flush, 0);
      chk("rf.rst.empty", empty, 1);
      chk("rf.rst.full", full, 0);
      chk("rf.rst.overflow", overflow, 0);
      chk("rf.rst.redirect_pc", redirect_pc, 0);
      @(negedge clk);
      rst = 1'b0;
      apply(mk(1,0,32'ha00,0, 0,0,0, 0,0,0,0,0,0, 2'b00), "rf.push2");
      apply(mk(0,0,0,0, 1,0,0, 0,1,0,0,0,0, 2'b00), "rf.pop2");

`ifdef BRU_STATS_EN
      rst = 1'b1;
      #1;
      chk("st.rst.br", br_count, 0);
      chk("st.rst.mp", mp_count, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         logic mis;
         mis = (i == 1 || i == 4 || i == 7);
         apply(mk(1,0,32'h1000 + 32'(i*16),0, 0,0,0, 0,0,0,0,0,0, 2'b00),
               $sformatf("st%0d.push", i));
         apply(mk(0,0,0,0, 1,mis,32'h2000, 0,1,0,mis,mis,32'h2000,
                  mis ? 2'b11 : 2'b00), $sformatf("st%0d.pop", i));
         if (mis) begin
            idle(0, 1, 0, 2'b11, $sformatf("st%0d.f1", i));
            idle(0, 1, 0, 2'b00, $sformatf("st%0d.f2", i));
         end
      end
      chk("st.br", br_count, 10);
      chk("st.mp", mp_count, 3);
      apply(mk(0,0,0,0, 1,1,32'h77, 0,1,0,0,0,0, 2'b00), "st.empty_res");
      chk("st.br_hold", br_count, 10);
      chk("st.mp_hold", mp_count, 3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
